// File: rtl/spu32_cpu_fetch_pkg.sv
// Shared CPU definitions for the fetch stage: bus widths, fetch FSM encodings
// and the FIFO entry layout.
package spu32_cpu_fetch_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_WAIT    = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [BUS_DATA_W-1:0] instr;
    logic [BUS_ADDR_W-1:0] pc;
  } fetch_entry_t;

  // Bus fetches are always word aligned; low address bits carry no meaning.
  function automatic logic [BUS_ADDR_W-1:0] word_align(input logic [BUS_ADDR_W-1:0] addr);
    return {addr[BUS_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/spu32_cpu_fetch_if.sv
// Instruction bus between the fetch stage (master) and memory (slave):
// registered strobe/address request, same-cycle ack with read data.
interface spu32_cpu_fetch_if;
  import spu32_cpu_fetch_pkg::*;

  logic [BUS_ADDR_W-1:0] O_bus_addr;
  logic                  O_bus_stb;
  logic                  I_bus_ack;
  logic [BUS_DATA_W-1:0] I_bus_data;

  modport master (
    output O_bus_addr,
    output O_bus_stb,
    input  I_bus_ack,
    input  I_bus_data
  );

  modport slave (
    input  O_bus_addr,
    input  O_bus_stb,
    output I_bus_ack,
    output I_bus_data
  );

endinterface

// File: rtl/spu32_cpu_fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {instr, pc} entries with flush,
// combinational head and occupancy count.
module spu32_cpu_fetch_fifo
  import spu32_cpu_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  fetch_entry_t               data_i,
  output fetch_entry_t               head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       valid_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            pop_ok;
  logic            push_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign valid_o = (count_q != '0);

endmodule

// File: rtl/spu32_cpu_fetch.sv
// CPU instruction fetch stage: PC tracking, single-outstanding bus reads,
// redirect/flush handling and a small buffer feeding the decoder.
module spu32_cpu_fetch
  import spu32_cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic                   I_clk,
  input  logic                   I_reset,
  input  logic                   I_take,
  input  logic                   I_redirect,
  input  logic [31:0]            I_redirect_pc,
  spu32_cpu_fetch_if.master      bus,
  output logic [31:0]            O_instr,
  output logic [31:0]            O_pc,
  output logic                   O_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          stb_q, stb_d;

  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic          has_free;
  logic          slot_after_push;
  logic [31:0]   pc_next;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign pc_next  = fetch_pc_q + 32'd4;
  assign pop      = I_take && O_valid && !I_redirect;
  assign has_free = (count < CW'(FIFO_DEPTH));
  // Occupancy after this cycle's push, net of a same-cycle pop by the decoder.
  assign slot_after_push =
    (({1'b0, count} + (CW+1)'(1) - (CW+1)'(pop)) < (CW+1)'(FIFO_DEPTH));

  assign push_entry.instr = bus.I_bus_data;
  assign push_entry.pc    = addr_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    stb_d      = stb_q;
    push       = 1'b0;

    if (I_redirect) begin
      fetch_pc_d = word_align(I_redirect_pc);
    end

    case (state_q)
      FETCH_IDLE: begin
        if (!I_redirect && has_free) begin
          state_d = FETCH_WAIT;
          addr_d  = fetch_pc_q;
          stb_d   = 1'b1;
        end
      end
      FETCH_WAIT: begin
        if (I_redirect) begin
          if (bus.I_bus_ack) begin
            state_d = FETCH_IDLE;
            stb_d   = 1'b0;
          end else begin
            state_d = FETCH_DISCARD;
          end
        end else if (bus.I_bus_ack) begin
          push       = 1'b1;
          fetch_pc_d = pc_next;
          if (slot_after_push) begin
            addr_d = pc_next;
          end else begin
            state_d = FETCH_IDLE;
            stb_d   = 1'b0;
          end
        end
      end
      FETCH_DISCARD: begin
        // The stale request must still complete on the bus before refetching.
        if (bus.I_bus_ack) begin
          state_d = FETCH_IDLE;
          stb_d   = 1'b0;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_VECTOR;
      addr_q     <= RESET_VECTOR;
      stb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      stb_q      <= stb_d;
    end
  end

  spu32_cpu_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (I_clk),
    .rst_i   (I_reset),
    .flush_i (I_redirect),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (count),
    .valid_o (O_valid)
  );

  assign bus.O_bus_addr = addr_q;
  assign bus.O_bus_stb  = stb_q;
  assign O_instr        = head.instr;
  assign O_pc           = head.pc;

endmodule

// File: tb/tb_spu32_cpu_fetch.sv
// Directed bench for the fetch stage: bus acks push expected {instr, pc}
// entries into a queue that is checked against the decoder-side head.
module tb_spu32_cpu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        take = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instr, pc;
  logic        valid;

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] expq [$];

  spu32_cpu_fetch_if bus_if ();

  spu32_cpu_fetch #(
    .RESET_VECTOR (32'h0000_0000),
    .FIFO_DEPTH   (2)
  ) dut (
    .I_clk         (clk),
    .I_reset       (rst),
    .I_take        (take),
    .I_redirect    (redirect),
    .I_redirect_pc (redirect_pc),
    .bus           (bus_if),
    .O_instr       (instr),
    .O_pc          (pc),
    .O_valid       (valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag);
    logic [63:0] e;
    if (expq.size() == 0) begin
      chk({tag, ".valid"}, 32'(valid), 32'd0);
    end else begin
      e = expq[0];
      chk({tag, ".valid"}, 32'(valid), 32'd1);
      chk({tag, ".instr"}, instr, e[63:32]);
      chk({tag, ".pc"}, pc, e[31:0]);
    end
  endtask

  task automatic chk_bus(input string tag, input logic stb, input logic [31:0] addr);
    chk({tag, ".stb"}, 32'(bus_if.O_bus_stb), 32'(stb));
    if (stb) chk({tag, ".addr"}, bus_if.O_bus_addr, addr);
  endtask

  // Drive an ack whose data the DUT is expected to keep, tagged with the bench's own address.
  task automatic ack_keep(input logic [31:0] data, input logic [31:0] addr);
    bus_if.I_bus_ack  = 1'b1;
    bus_if.I_bus_data = data;
    expq.push_back({data, addr});
  endtask

  task automatic ack_drop(input logic [31:0] data);
    bus_if.I_bus_ack  = 1'b1;
    bus_if.I_bus_data = data;
  endtask

  task automatic bus_idle();
    bus_if.I_bus_ack  = 1'b0;
    bus_if.I_bus_data = 32'h0;
  endtask

  initial begin
    bus_idle();
    #1 rst = 1'b1;
    tick();
    tick();
    chk_bus("rst", 1'b0, 32'h0);
    chk("rst.addr", bus_if.O_bus_addr, 32'h0);
    chk("rst.instr", instr, 32'h0);
    chk("rst.pc", pc, 32'h0);
    chk_head("rst");

    // First fetch after reset release, zero-wait bus.
    rst = 1'b0;
    tick();
    chk_bus("first_req", 1'b1, 32'h0);
    ack_keep(32'h0000_0013, 32'h0);
    tick();
    chk_head("first_word");
    chk_bus("second_req", 1'b1, 32'h4);
    ack_keep(32'h0010_0093, 32'h4);
    tick();
    bus_idle();
    chk_bus("full_stop", 1'b0, 32'h0);
    chk_head("full_head");
    tick();
    chk_bus("full_hold", 1'b0, 32'h0);
    chk_head("full_hold");

    // One take frees one slot, giving exactly one new fetch at addr 8.
    take = 1'b1;
    tick();
    take = 1'b0;
    void'(expq.pop_front());
    chk_head("after_take");
    tick();
    chk_bus("refill_req", 1'b1, 32'h8);
    ack_keep(32'h0000_000A, 32'h8);
    tick();
    bus_idle();
    chk_bus("refill_stop", 1'b0, 32'h0);
    chk_head("refill_head");

    // Redirect in IDLE with a take: flush wins, low target bits forced to zero.
    redirect = 1'b1;
    redirect_pc = 32'h0000_0203;
    take = 1'b1;
    tick();
    redirect = 1'b0;
    take = 1'b0;
    expq.delete();
    chk_head("idle_redir");
    tick();
    chk_bus("idle_redir_req", 1'b1, 32'h200);

    // Redirect while the request is outstanding; ack arrives 3 cycles later.
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk_head("wait_redir");
    chk_bus("discard_hold0", 1'b1, 32'h200);
    tick();
    chk_bus("discard_hold1", 1'b1, 32'h200);
    tick();
    ack_drop(32'hDEAD_BEEF);
    tick();
    bus_idle();
    chk_bus("discard_done", 1'b0, 32'h0);
    chk_head("discard_done");
    tick();
    chk_bus("redir_target", 1'b1, 32'h100);
    chk_head("redir_target");

    // Redirect, take and ack all in one cycle.
    ack_keep(32'h0000_0011, 32'h100);
    tick();
    chk_head("pre_combo");
    chk_bus("pre_combo", 1'b1, 32'h104);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0300;
    take = 1'b1;
    ack_drop(32'h0000_0022);
    tick();
    redirect = 1'b0;
    take = 1'b0;
    bus_idle();
    expq.delete();
    chk_head("combo");
    chk_bus("combo", 1'b0, 32'h0);
    tick();
    chk_bus("combo_target", 1'b1, 32'h300);

    // Asynchronous reset in WAIT with a valid entry, then a stray ack.
    ack_keep(32'h0000_0033, 32'h300);
    tick();
    bus_idle();
    chk_head("pre_reset");
    rst = 1'b1;
    #1;
    expq.delete();
    chk_bus("async_rst", 1'b0, 32'h0);
    chk("async_rst.addr", bus_if.O_bus_addr, 32'h0);
    chk_head("async_rst");
    @(negedge clk);
    rst = 1'b0;
    ack_drop(32'h0000_0BAD);
    tick();
    bus_idle();
    chk_head("stray_ack");
    chk_bus("restart", 1'b1, 32'h0);
    ack_keep(32'h0000_0044, 32'h0);
    tick();
    bus_idle();
    chk_head("restart_word");

    // PC wrap at the top of the address space.
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    ack_drop(32'h0000_0077);
    tick();
    redirect = 1'b0;
    bus_idle();
    expq.delete();
    chk_head("wrap_redir");
    tick();
    chk_bus("wrap_req", 1'b1, 32'hFFFF_FFFC);
    ack_keep(32'h0000_0055, 32'hFFFF_FFFC);
    tick();
    chk_head("wrap_word");
    chk_bus("wrapped_req", 1'b1, 32'h0);
    ack_keep(32'h0000_0066, 32'h0);
    tick();
    bus_idle();
    chk_bus("wrap_full", 1'b0, 32'h0);

    // Drain both entries through the decoder side.
    take = 1'b1;
    chk_head("drain0");
    tick();
    void'(expq.pop_front());
    chk_head("drain1");
    tick();
    void'(expq.pop_front());
    take = 1'b0;
    chk_head("drained");
    tick();
    chk_bus("post_drain", 1'b1, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
